// File: rtl/wish_pack.sv
// Wishbone-style gearbox: packs NUM_PACK narrow source words into one wide
// destination word, carrying SOP/EOP framing and flushing early on EOP.
module wish_pack #(
  parameter int DATA_WIDTH    = 8,
  parameter int NUM_PACK      = 4,
  parameter int LITTLE_ENDIAN = 1,
  parameter int FLUSH_ON_EOP  = 1
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           s_stb_i,
  input  logic                           s_cyc_i,
  output logic                           s_ack_o,
  output logic                           s_stall_o,
  input  logic [DATA_WIDTH-1:0]          s_dat_i,
  input  logic [1:0]                     s_tgc_i,
  output logic                           d_stb_o,
  output logic                           d_cyc_o,
  input  logic                           d_ack_i,
  output logic [NUM_PACK*DATA_WIDTH-1:0] d_dat_o,
  output logic [1:0]                     d_tgc_o
);

  localparam int WW = NUM_PACK * DATA_WIDTH;
  localparam int CW = $clog2(NUM_PACK);
  localparam logic [CW-1:0] LAST = CW'(NUM_PACK - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [WW-1:0] acc_q, acc_d;
  logic          first_sop_q, first_sop_d;
  logic          out_valid_q, out_valid_d;
  logic [WW-1:0] out_dat_q, out_dat_d;
  logic [1:0]    out_tgc_q, out_tgc_d;

  logic [CW-1:0] lane_sel;
  logic [WW-1:0] merged;
  logic          closing;
  logic          accept;

  assign lane_sel  = (LITTLE_ENDIAN != 0) ? cnt_q : (LAST - cnt_q);
  assign closing   = (cnt_q == LAST) | ((FLUSH_ON_EOP != 0) & s_tgc_i[1]);
  // Only the closing word needs the output register, so only it can stall.
  assign s_stall_o = !rst_i & closing & out_valid_q & !d_ack_i;
  assign s_ack_o   = !rst_i & !s_stall_o;
  assign accept    = s_stb_i & s_cyc_i & s_ack_o;

  generate
    for (genvar gi = 0; gi < NUM_PACK; gi++) begin : g_lane
      assign merged[gi*DATA_WIDTH +: DATA_WIDTH] =
        (lane_sel == CW'(gi)) ? s_dat_i : acc_q[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  always_comb begin
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    first_sop_d = first_sop_q;
    out_valid_d = out_valid_q;
    out_dat_d   = out_dat_q;
    out_tgc_d   = out_tgc_q;
    if (accept && closing) begin
      out_dat_d   = merged;
      out_tgc_d   = {s_tgc_i[1], (cnt_q == '0) ? s_tgc_i[0] : first_sop_q};
      out_valid_d = 1'b1;
      acc_d       = '0;
      cnt_d       = '0;
    end else begin
      if (accept) begin
        acc_d = merged;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == '0) first_sop_d = s_tgc_i[0];
      end
      if (d_ack_i && out_valid_q) out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q       <= '0;
      acc_q       <= '0;
      first_sop_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_dat_q   <= '0;
      out_tgc_q   <= '0;
    end else begin
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      first_sop_q <= first_sop_d;
      out_valid_q <= out_valid_d;
      out_dat_q   <= out_dat_d;
      out_tgc_q   <= out_tgc_d;
    end
  end

  assign d_stb_o = !rst_i & out_valid_q;
  assign d_cyc_o = d_stb_o;
  assign d_dat_o = rst_i ? '0 : out_dat_q;
  assign d_tgc_o = rst_i ? 2'b00 : out_tgc_q;

endmodule
